// File: rtl/fust_scalar_table.sv
// Scalar functional-unit status table: one row per FU tracking operand producer tags,
// waking rows on writeback and presenting ready rows to their FU for issue.
module fust_scalar_table #(
    parameter int NUM_FU = 3,
    parameter int TAG_W  = 2,
    parameter int REG_W  = 5,
    parameter int OP_W   = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      flush,
    input  logic                      freeze,
    input  logic                      disp_en,
    input  logic [TAG_W-1:0]          disp_fu,
    input  logic [OP_W-1:0]           disp_op,
    input  logic [REG_W-1:0]          disp_rd,
    input  logic [REG_W-1:0]          disp_rs1,
    input  logic [REG_W-1:0]          disp_rs2,
    input  logic [TAG_W-1:0]          disp_t1,
    input  logic [TAG_W-1:0]          disp_t2,
    input  logic                      wb_en,
    input  logic [TAG_W-1:0]          wb_tag,
    input  logic [NUM_FU-1:0]         fu_ready,
    output logic [NUM_FU-1:0]         busy,
    output logic [NUM_FU*2-1:0]       state,
    output logic [NUM_FU*TAG_W-1:0]   t1_out,
    output logic [NUM_FU*TAG_W-1:0]   t2_out,
    output logic [NUM_FU-1:0]         issue_valid,
    output logic [NUM_FU*OP_W-1:0]    issue_op,
    output logic [NUM_FU*REG_W-1:0]   issue_rd,
    output logic [NUM_FU*REG_W-1:0]   issue_rs1,
    output logic [NUM_FU*REG_W-1:0]   issue_rs2,
    output logic                      disp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } row_state_e;

    row_state_e       state_q [NUM_FU];
    row_state_e       state_d [NUM_FU];
    logic [TAG_W-1:0] t1_q    [NUM_FU];
    logic [TAG_W-1:0] t1_d    [NUM_FU];
    logic [TAG_W-1:0] t2_q    [NUM_FU];
    logic [TAG_W-1:0] t2_d    [NUM_FU];
    logic [OP_W-1:0]  op_q    [NUM_FU];
    logic [OP_W-1:0]  op_d    [NUM_FU];
    logic [REG_W-1:0] rd_q    [NUM_FU];
    logic [REG_W-1:0] rd_d    [NUM_FU];
    logic [REG_W-1:0] rs1_q   [NUM_FU];
    logic [REG_W-1:0] rs1_d   [NUM_FU];
    logic [REG_W-1:0] rs2_q   [NUM_FU];
    logic [REG_W-1:0] rs2_d   [NUM_FU];
    logic             disp_err_q;
    logic             disp_err_d;

    logic             wb_hit;
    logic             disp_in_range;
    logic             disp_row_idle;
    logic             disp_accept;
    logic [TAG_W-1:0] t1_in;
    logic [TAG_W-1:0] t2_in;

    // Decode writeback validity and dispatch acceptance; incoming tags produced by the
    // completing FU this very cycle are bypassed to ready.
    always_comb begin
        wb_hit        = wb_en && (wb_tag != '0) && (int'(wb_tag) <= NUM_FU);
        disp_in_range = int'(disp_fu) < NUM_FU;
        disp_row_idle = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (disp_fu == TAG_W'(k) && state_q[k] == IDLE) begin
                disp_row_idle = 1'b1;
            end
        end
        disp_accept = disp_en && !freeze && !flush && disp_in_range && disp_row_idle;
        disp_err_d  = disp_en && !disp_accept;
        t1_in       = (wb_hit && disp_t1 == wb_tag) ? '0 : disp_t1;
        t2_in       = (wb_hit && disp_t2 == wb_tag) ? '0 : disp_t2;
    end

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            state_d[k] = state_q[k];
            op_d[k]    = op_q[k];
            rd_d[k]    = rd_q[k];
            rs1_d[k]   = rs1_q[k];
            rs2_d[k]   = rs2_q[k];
            t1_d[k]    = (wb_hit && t1_q[k] == wb_tag) ? '0 : t1_q[k];
            t2_d[k]    = (wb_hit && t2_q[k] == wb_tag) ? '0 : t2_q[k];
            case (state_q[k])
                IDLE: begin
                    if (disp_accept && disp_fu == TAG_W'(k)) begin
                        op_d[k]    = disp_op;
                        rd_d[k]    = disp_rd;
                        rs1_d[k]   = disp_rs1;
                        rs2_d[k]   = disp_rs2;
                        t1_d[k]    = t1_in;
                        t2_d[k]    = t2_in;
                        state_d[k] = (t1_in == '0 && t2_in == '0) ? READY : WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_d[k] = IDLE;
                        t1_d[k]    = '0;
                        t2_d[k]    = '0;
                    end else if (t1_q[k] == '0 && t2_q[k] == '0) begin
                        state_d[k] = READY;
                    end
                end
                READY: begin
                    if (flush) begin
                        state_d[k] = IDLE;
                        t1_d[k]    = '0;
                        t2_d[k]    = '0;
                    end else if (!freeze && fu_ready[k]) begin
                        state_d[k] = EXEC;
                    end
                end
                EXEC: begin
                    // In-flight work is never squashed; only its own writeback retires it.
                    if (wb_hit && wb_tag == TAG_W'(k + 1)) begin
                        state_d[k] = IDLE;
                    end
                end
                default: state_d[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NUM_FU; k++) begin
                state_q[k] <= IDLE;
                t1_q[k]    <= '0;
                t2_q[k]    <= '0;
                op_q[k]    <= '0;
                rd_q[k]    <= '0;
                rs1_q[k]   <= '0;
                rs2_q[k]   <= '0;
            end
            disp_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                state_q[k] <= state_d[k];
                t1_q[k]    <= t1_d[k];
                t2_q[k]    <= t2_d[k];
                op_q[k]    <= op_d[k];
                rd_q[k]    <= rd_d[k];
                rs1_q[k]   <= rs1_d[k];
                rs2_q[k]   <= rs2_d[k];
            end
            disp_err_q <= disp_err_d;
        end
    end

    always_comb begin
        busy        = '0;
        state       = '0;
        t1_out      = '0;
        t2_out      = '0;
        issue_valid = '0;
        issue_op    = '0;
        issue_rd    = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            busy[k]                   = state_q[k] != IDLE;
            state[2*k +: 2]           = state_q[k];
            t1_out[TAG_W*k +: TAG_W]  = t1_q[k];
            t2_out[TAG_W*k +: TAG_W]  = t2_q[k];
            issue_valid[k]            = (state_q[k] == READY) && !freeze;
            issue_op[OP_W*k +: OP_W]  = op_q[k];
            issue_rd[REG_W*k +: REG_W]  = rd_q[k];
            issue_rs1[REG_W*k +: REG_W] = rs1_q[k];
            issue_rs2[REG_W*k +: REG_W] = rs2_q[k];
        end
        disp_err = disp_err_q;
    end

endmodule
